// File: rtl/logic_axi4_stream_to_avalon_st_pkg.sv
// Shared types and helpers for the AXI4-Stream to Avalon-ST bridge.
// Helpers work on MAX_BYTES-wide vectors; callers zero-extend and pass the live byte count.
package logic_axi4_stream_to_avalon_st_pkg;

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        IN_PACKET = 1'b1
    } state_t;

    localparam int MAX_BYTES = 64;

    typedef struct packed {
        logic [7:0] empty;
        logic       contiguous;
    } keep_info_t;

    // An all-zero keep reports n_bytes-1 so the beat still looks like one symbol wide.
    function automatic keep_info_t keep_to_empty(input logic [MAX_BYTES-1:0] keep, input int n_bytes);
        keep_info_t info;
        int         ones;
        logic       seen_gap;
        ones            = 0;
        seen_gap        = 1'b0;
        info.contiguous = 1'b1;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (i < n_bytes) begin
                if (keep[i]) begin
                    ones++;
                    if (seen_gap) info.contiguous = 1'b0;
                end else begin
                    seen_gap = 1'b1;
                end
            end
        end
        if (ones == 0) info.empty = 8'(n_bytes - 1);
        else           info.empty = 8'(n_bytes - ones);
        return info;
    endfunction

    function automatic logic [MAX_BYTES*8-1:0] reorder_bytes(input logic [MAX_BYTES*8-1:0] data, input int n_bytes);
        logic [MAX_BYTES*8-1:0] res;
        res = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (i < n_bytes) res[(n_bytes-1-i)*8 +: 8] = data[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/logic_axi4_stream_to_avalon_st_skid.sv
// Two-entry registered skid buffer: output register plus one overflow register.
// Ready is registered and drops only once both entries are occupied.
module logic_axi4_stream_to_avalon_st_skid #(
    parameter int WIDTH = 8
) (
    input  logic             aclk,
    input  logic             areset_n,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_ready
);

    logic [1:0]       r_count;
    logic             r_ready;
    logic             r_out_valid;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [WIDTH-1:0] r_skid_data;
    logic             w_push;
    logic             w_pop;
    logic [1:0]       w_count_next;

    assign w_push = i_valid & r_ready;
    assign w_pop  = r_out_valid & i_ready;

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop)      w_count_next = r_count + 2'd1;
        else if (!w_push && w_pop) w_count_next = r_count - 2'd1;
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_count      <= 2'd0;
            r_ready      <= 1'b0;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_out_data   <= '0;
            r_skid_data  <= '0;
        end else begin
            r_count <= w_count_next;
            r_ready <= (w_count_next < 2'd2);
            if (!r_out_valid || w_pop) begin
                // Output slot frees up: the older skid entry always goes first.
                if (r_skid_valid) begin
                    r_out_valid  <= 1'b1;
                    r_out_data   <= r_skid_data;
                    r_skid_valid <= w_push;
                    if (w_push) r_skid_data <= i_data;
                end else begin
                    r_out_valid <= w_push;
                    if (w_push) r_out_data <= i_data;
                end
            end else if (w_push) begin
                r_skid_valid <= 1'b1;
                r_skid_data  <= i_data;
            end
        end
    end

    assign o_ready = r_ready;
    assign o_valid = r_out_valid;
    assign o_data  = r_out_data;

endmodule

// File: rtl/logic_axi4_stream_to_avalon_st.sv
// AXI4-Stream slave to Avalon-ST source (ready latency 0) through a registered skid buffer.
// Optional macro LOGIC_AXI4_STREAM_TO_AVALON_ST_TID_CHECK_EN flags tid changes inside a packet.
module logic_axi4_stream_to_avalon_st
    import logic_axi4_stream_to_avalon_st_pkg::*;
#(
    parameter int TDATA_BYTES                     = 4,
    parameter int TDEST_WIDTH                     = 1,
    parameter int TUSER_WIDTH                     = 1,
    parameter int TID_WIDTH                       = 1,
    parameter int USE_TKEEP                       = 1,
    parameter int USE_TLAST                       = 1,
    parameter int ERROR_WIDTH                     = 1,
    parameter int EMPTY_WIDTH                     = (TDATA_BYTES >= 2) ? $clog2(TDATA_BYTES) : 1,
    parameter int FIRST_SYMBOL_IN_HIGH_ORDER_BITS = 1
) (
    input  logic                     aclk,
    input  logic                     areset_n,
    input  logic                     rx_tvalid,
    input  logic                     rx_tlast,
    input  logic [TDATA_BYTES*8-1:0] rx_tdata,
    input  logic [TDATA_BYTES-1:0]   rx_tkeep,
    input  logic [TDATA_BYTES-1:0]   rx_tstrb,
    input  logic [TDEST_WIDTH-1:0]   rx_tdest,
    input  logic [TUSER_WIDTH-1:0]   rx_tuser,
    input  logic [TID_WIDTH-1:0]     rx_tid,
    output logic                     rx_tready,
    output logic                     tx_valid,
    output logic                     tx_startofpacket,
    output logic                     tx_endofpacket,
    output logic [TID_WIDTH-1:0]     tx_channel,
    output logic [ERROR_WIDTH-1:0]   tx_error,
    output logic [EMPTY_WIDTH-1:0]   tx_empty,
    output logic [TDATA_BYTES*8-1:0] tx_data,
    input  logic                     tx_ready
);

    localparam int PAYLOAD_W = 2 + TID_WIDTH + ERROR_WIDTH + EMPTY_WIDTH + TDATA_BYTES*8;

    state_t                   r_state;
    state_t                   w_state_next;
    logic                     w_sop;
    logic                     w_eop;
    logic                     w_push;
    logic                     w_tid_err;
    logic                     w_keep_viol;
    logic [TDATA_BYTES-1:0]   w_keep;
    logic [MAX_BYTES-1:0]     w_keep_ext;
    logic [MAX_BYTES*8-1:0]   w_data_ext;
    logic [MAX_BYTES*8-1:0]   w_data_swapped;
    keep_info_t               w_keep_info;
    logic [EMPTY_WIDTH-1:0]   w_empty;
    logic [ERROR_WIDTH-1:0]   w_error;
    logic [TDATA_BYTES*8-1:0] w_data;
    logic [PAYLOAD_W-1:0]     w_payload_in;
    logic [PAYLOAD_W-1:0]     w_payload_out;
    logic                     w_unused;

    assign w_push = rx_tvalid & rx_tready;
    assign w_keep = (USE_TKEEP != 0) ? rx_tkeep : '1;
    assign w_eop  = (USE_TLAST != 0) ? rx_tlast : 1'b1;

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) r_state <= IDLE;
        else           r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (w_push && (USE_TLAST != 0)) begin
            case (r_state)
                IDLE:      if (!rx_tlast) w_state_next = IN_PACKET;
                IN_PACKET: if (rx_tlast)  w_state_next = IDLE;
                default:   w_state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        w_sop = (r_state == IDLE);
    end

`ifdef LOGIC_AXI4_STREAM_TO_AVALON_ST_TID_CHECK_EN
    logic [TID_WIDTH-1:0] r_first_tid;

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n)                     r_first_tid <= '0;
        else if (w_push && r_state == IDLE) r_first_tid <= rx_tid;
    end

    assign w_tid_err = (r_state == IN_PACKET) && (rx_tid != r_first_tid);
`else
    assign w_tid_err = 1'b0;
`endif

    always_comb begin
        w_keep_ext                       = '0;
        w_keep_ext[TDATA_BYTES-1:0]      = w_keep;
        w_data_ext                       = '0;
        w_data_ext[TDATA_BYTES*8-1:0]    = rx_tdata;
    end

    assign w_keep_info    = keep_to_empty(w_keep_ext, TDATA_BYTES);
    assign w_data_swapped = reorder_bytes(w_data_ext, TDATA_BYTES);
    assign w_data         = (FIRST_SYMBOL_IN_HIGH_ORDER_BITS != 0) ? w_data_swapped[TDATA_BYTES*8-1:0] : rx_tdata;
    assign w_empty        = w_eop ? w_keep_info.empty[EMPTY_WIDTH-1:0] : '0;
    assign w_keep_viol    = !w_keep_info.contiguous || (!w_eop && !(&w_keep)) || !(|w_keep);

    assign w_error[0] = rx_tuser[0] | w_keep_viol | w_tid_err;
    generate
        for (genvar gi = 1; gi < ERROR_WIDTH; gi++) begin : g_error
            if (gi < TUSER_WIDTH) begin : g_user
                assign w_error[gi] = rx_tuser[gi];
            end else begin : g_zero
                assign w_error[gi] = 1'b0;
            end
        end
    endgenerate

    assign w_payload_in = {w_sop, w_eop, rx_tid, w_error, w_empty, w_data};

    logic_axi4_stream_to_avalon_st_skid #(
        .WIDTH (PAYLOAD_W)
    ) u_skid (
        .aclk     (aclk),
        .areset_n (areset_n),
        .i_valid  (rx_tvalid),
        .i_data   (w_payload_in),
        .o_ready  (rx_tready),
        .o_valid  (tx_valid),
        .o_data   (w_payload_out),
        .i_ready  (tx_ready)
    );

    assign {tx_startofpacket, tx_endofpacket, tx_channel, tx_error, tx_empty, tx_data} = w_payload_out;

    // Inputs that are accepted but intentionally not forwarded.
    assign w_unused = ^{rx_tstrb, rx_tdest, rx_tuser, rx_tkeep, rx_tlast, w_data_swapped, w_keep_info.empty};

endmodule

// File: tb/tb_logic_axi4_stream_to_avalon_st.sv
// Randomized scoreboard bench for logic_axi4_stream_to_avalon_st (TDATA_BYTES=4, TID_WIDTH=2).
// Build with LOGIC_AXI4_STREAM_TO_AVALON_ST_TID_CHECK_EN to exercise the tid check.
`timescale 1ns/1ps
module tb_logic_axi4_stream_to_avalon_st;

    logic        aclk = 1'b0;
    logic        areset_n = 1'b0;
    logic        rx_tvalid = 1'b0;
    logic        rx_tlast = 1'b0;
    logic [31:0] rx_tdata = '0;
    logic [3:0]  rx_tkeep = '0;
    logic [3:0]  rx_tstrb = '0;
    logic [0:0]  rx_tdest = '0;
    logic [0:0]  rx_tuser = '0;
    logic [1:0]  rx_tid = '0;
    logic        rx_tready;
    logic        tx_valid;
    logic        tx_startofpacket;
    logic        tx_endofpacket;
    logic [1:0]  tx_channel;
    logic [0:0]  tx_error;
    logic [1:0]  tx_empty;
    logic [31:0] tx_data;
    logic        tx_ready = 1'b0;

    always #5 aclk = ~aclk;

    logic_axi4_stream_to_avalon_st #(
        .TDATA_BYTES (4),
        .TID_WIDTH   (2)
    ) dut (
        .aclk             (aclk),
        .areset_n         (areset_n),
        .rx_tvalid        (rx_tvalid),
        .rx_tlast         (rx_tlast),
        .rx_tdata         (rx_tdata),
        .rx_tkeep         (rx_tkeep),
        .rx_tstrb         (rx_tstrb),
        .rx_tdest         (rx_tdest),
        .rx_tuser         (rx_tuser),
        .rx_tid           (rx_tid),
        .rx_tready        (rx_tready),
        .tx_valid         (tx_valid),
        .tx_startofpacket (tx_startofpacket),
        .tx_endofpacket   (tx_endofpacket),
        .tx_channel       (tx_channel),
        .tx_error         (tx_error),
        .tx_empty         (tx_empty),
        .tx_data          (tx_data),
        .tx_ready         (tx_ready)
    );

    typedef struct {
        logic        sop;
        logic        eop;
        logic [1:0]  ch;
        logic        err;
        logic [1:0]  empty;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    bit         lat_check = 1'b1;
    bit         m_in_pkt = 1'b0;
    logic [1:0] m_first_tid = '0;
    bit         rand_done;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge aclk) cyc <= cyc + 1;

    // Scoreboard: expected beats are built from the AXI side and retired on the Avalon side.
    always @(negedge aclk) begin
        exp_t e;
        int   ones;
        bit   contig;
        bit   viol;
        if (areset_n) begin
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'(tx_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sop", 64'(tx_startofpacket), 64'(e.sop));
                    check("eop", 64'(tx_endofpacket), 64'(e.eop));
                    check("channel", 64'(tx_channel), 64'(e.ch));
                    check("error", 64'(tx_error), 64'(e.err));
                    check("empty", 64'(tx_empty), 64'(e.empty));
                    check("data", 64'(tx_data), 64'(e.data));
                    if (lat_check) check("latency", 64'(cyc - e.cyc), 64'd1);
                end
            end
            if (rx_tvalid && rx_tready) begin
                ones   = $countones(rx_tkeep);
                contig = (rx_tkeep == 4'((1 << ones) - 1));
                viol   = !contig || (!rx_tlast && rx_tkeep != 4'hF) || (rx_tkeep == 4'h0);
                e.sop  = !m_in_pkt;
                e.eop  = rx_tlast;
                e.ch   = rx_tid;
                e.err  = rx_tuser[0] | viol;
`ifdef LOGIC_AXI4_STREAM_TO_AVALON_ST_TID_CHECK_EN
                if (m_in_pkt && rx_tid != m_first_tid) e.err = 1'b1;
`endif
                if (!m_in_pkt) m_first_tid = rx_tid;
                if (!rx_tlast)             e.empty = 2'd0;
                else if (rx_tkeep == 4'h0) e.empty = 2'd3;
                else                       e.empty = 2'(4 - ones);
                e.data = {rx_tdata[7:0], rx_tdata[15:8], rx_tdata[23:16], rx_tdata[31:24]};
                e.cyc  = cyc;
                m_in_pkt = !rx_tlast;
                exp_q.push_back(e);
                $display("beat in : data=%08h keep=%h last=%0d tid=%0d user=%0d", rx_tdata, rx_tkeep, rx_tlast, rx_tid, rx_tuser);
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l, input logic [1:0] id, input logic u);
        bit done;
        done      = 1'b0;
        rx_tvalid = 1'b1;
        rx_tdata  = d;
        rx_tkeep  = k;
        rx_tstrb  = k;
        rx_tlast  = l;
        rx_tid    = id;
        rx_tuser  = u;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge aclk);
            done = rx_tready;
            @(posedge aclk);
            #1;
        end
        if (!done) check("send_timeout", 64'(rx_tready), 64'd1);
    endtask

    task automatic idle(input int n);
        rx_tvalid = 1'b0;
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && exp_q.size() != 0; t++) begin
            @(posedge aclk);
            #1;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int c0;
        #2;
        check("rst_tx_valid", 64'(tx_valid), 64'd0);
        check("rst_rx_tready", 64'(rx_tready), 64'd0);
        check("rst_sop_eop", 64'({tx_startofpacket, tx_endofpacket}), 64'd0);
        check("rst_fields", 64'({tx_channel, tx_error, tx_empty, tx_data}), 64'd0);
        #10 areset_n = 1'b1;
        @(posedge aclk);
        #1;
        check("rx_tready_after_reset", 64'(rx_tready), 64'd1);
        tx_ready = 1'b1;

        // 3-beat packet, tid=2, tail keep 0x3
        send(32'hA3A2A1A0, 4'hF, 1'b0, 2'd2, 1'b0);
        send(32'hB3B2B1B0, 4'hF, 1'b0, 2'd2, 1'b0);
        send(32'hC3C2C1C0, 4'h3, 1'b1, 2'd2, 1'b0);
        check("pkt3_tail_empty", 64'(tx_empty), 64'd2);
        idle(2);

        // back-to-back single-beat packets at full rate
        c0 = cyc;
        for (int i = 0; i < 8; i++) send($urandom, 4'hF, 1'b1, 2'(i), 1'b0);
        check("throughput_cycles", 64'(cyc - c0), 64'd8);
        idle(2);

        send(32'h44332211, 4'hF, 1'b1, 2'd0, 1'b0);
        check("byte_order", 64'(tx_data), 64'h11223344);
        idle(1);

        // keep violations and tuser
        send(32'h01020304, 4'h5, 1'b1, 2'd1, 1'b0);
        check("keep5_error", 64'(tx_error), 64'd1);
        check("keep5_empty", 64'(tx_empty), 64'd2);
        send(32'h05060708, 4'h7, 1'b0, 2'd1, 1'b0);
        check("keep7_noeop_error", 64'(tx_error), 64'd1);
        send(32'h090A0B0C, 4'hF, 1'b1, 2'd1, 1'b0);
        send(32'h0D0E0F10, 4'hF, 1'b1, 2'd1, 1'b1);
        check("tuser_error", 64'(tx_error), 64'd1);
        send(32'h11121314, 4'h0, 1'b1, 2'd1, 1'b0);
        check("keep0_empty", 64'(tx_empty), 64'd3);
        idle(2);

        // backpressure: 5-cycle tx_ready stall while streaming
        lat_check = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) send($urandom, 4'hF, 1'(i % 3 == 2), 2'd3, 1'b0);
                rx_tvalid = 1'b0;
            end
            begin
                repeat (2) begin @(posedge aclk); #1; end
                tx_ready = 1'b0;
                repeat (4) begin @(posedge aclk); #1; end
                check("bp_rx_tready_low", 64'(rx_tready), 64'd0);
                check("bp_tx_valid_held", 64'(tx_valid), 64'd1);
                @(posedge aclk);
                #1;
                tx_ready = 1'b1;
            end
        join
        drain();

        // randomized traffic with random backpressure and gaps
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    logic [3:0] k;
                    k = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF;
                    send($urandom, k, 1'($urandom_range(0, 2) == 0), 2'($urandom), 1'($urandom_range(0, 9) == 0));
                    if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
                end
                rx_tvalid = 1'b0;
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    tx_ready = ($urandom_range(0, 3) != 0);
                    @(posedge aclk);
                    #1;
                end
                tx_ready = 1'b1;
            end
        join
        drain();
        idle(1);

        // reset in the middle of a packet
        lat_check = 1'b1;
        send(32'hDEAD0001, 4'hF, 1'b0, 2'd1, 1'b0);
        rx_tvalid = 1'b0;
        #2;
        areset_n = 1'b0;
        exp_q.delete();
        m_in_pkt = 1'b0;
        #1;
        check("rst_mid_tx_valid", 64'(tx_valid), 64'd0);
        @(posedge aclk);
        #3;
        areset_n = 1'b1;
        @(posedge aclk);
        #1;
        check("no_stale_tx_valid", 64'(tx_valid), 64'd0);
        send(32'hBEEF0001, 4'hF, 1'b0, 2'd1, 1'b0);
        check("sop_after_reset", 64'(tx_startofpacket), 64'd1);
`ifdef LOGIC_AXI4_STREAM_TO_AVALON_ST_TID_CHECK_EN
        send(32'hBEEF0002, 4'hF, 1'b0, 2'd3, 1'b0);
        check("tid_change_error", 64'(tx_error), 64'd1);
`endif
        send(32'hBEEF0003, 4'hF, 1'b1, 2'd1, 1'b0);
        idle(1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/logic_axi4_stream_to_avalon_st.md
Name: logic_axi4_stream_to_avalon_st

Overview:
Converts an AXI4-Stream slave interface into an Avalon-ST source with ready latency 0. It is the inverse of the Avalon-ST to AXI4-Stream bridge.
- Generates startofpacket from packet-boundary tracking.
- Converts tkeep to empty and reorders bytes for the Avalon symbol order.
- Maps tid to channel.
- Fully registered through a 2-entry skid buffer, so both handshake directions are timing-isolated at full throughput.

Parameters:
- TDATA_BYTES, 4, data width in bytes (Avalon symbols per beat, 8-bit symbols).
- TDEST_WIDTH, 1, rx_tdest width; tdest is accepted and discarded.
- TUSER_WIDTH, 1, rx_tuser width.
- TID_WIDTH, 1, rx_tid width, and also tx_channel width.
- USE_TKEEP, 1, 0 means all bytes are treated as kept.
- USE_TLAST, 1, 0 means every beat is a single-beat packet.
- ERROR_WIDTH, 1, tx_error width.
- EMPTY_WIDTH, (TDATA_BYTES >= 2) ? $clog2(TDATA_BYTES) : 1, tx_empty width.
- FIRST_SYMBOL_IN_HIGH_ORDER_BITS, 1, 1 means AXI byte 0 goes to tx_data[TDATA_BYTES-1].

Ports:
- aclk  in  1  clock
- areset_n  in  1  asynchronous active-low reset
- rx_tvalid  in  1  AXI valid
- rx_tlast  in  1  AXI last
- rx_tdata  in  TDATA_BYTES x 8  AXI data
- rx_tkeep  in  TDATA_BYTES  byte keep
- rx_tstrb  in  TDATA_BYTES  ignored
- rx_tdest  in  TDEST_WIDTH  ignored
- rx_tuser  in  TUSER_WIDTH  error source
- rx_tid  in  TID_WIDTH  stream id
- rx_tready  out  1  AXI ready
- tx_valid  out  1  Avalon valid
- tx_startofpacket  out  1  first beat of packet
- tx_endofpacket  out  1  last beat of packet
- tx_channel  out  TID_WIDTH  rx_tid of the beat
- tx_error  out  ERROR_WIDTH  error flags
- tx_empty  out  EMPTY_WIDTH  unused symbols on the end-of-packet beat
- tx_data  out  TDATA_BYTES x 8  Avalon data
- tx_ready  in  1  Avalon ready, ready latency 0

Behaviour:
- Reset (areset_n=0, asynchronous): all outputs are 0, including rx_tready; the buffer is emptied and the FSM goes to IDLE. rx_tready rises on the first aclk edge after release.
- Handshakes:
  - AXI transfer occurs when rx_tvalid & rx_tready.
  - Avalon transfer occurs when tx_valid & tx_ready.
  - tx_valid is never dependent on tx_ready.
  - The presented beat holds stable until it is accepted.
- Skid buffer:
  - 2 entries; rx_tready = registered (entries < 2 after the current edge).
  - Latency: an accepted beat appears on tx_* on the next cycle when the buffer is empty.
  - Sustains 1 beat/cycle with tx_ready=1.
  - Simultaneous push and pop keeps the occupancy unchanged.
  - Full state: rx_tready=0 until a pop.
- Packet FSM, evaluated on an accepted AXI beat:
  - IDLE: the beat gets sop=1. On tlast=0 go to IN_PACKET; on tlast=1 stay in IDLE.
  - IN_PACKET: the beat gets sop=0. On tlast=1 go to IDLE.
  - eop = tlast.
  - USE_TLAST=0: sop=eop=1 on every beat, and the FSM stays in IDLE.
- Empty:
  - On an eop beat, empty = TDATA_BYTES - popcount(tkeep), with tkeep expected contiguous from byte 0. On non-eop beats empty=0.
  - Width rule: the result is truncated to EMPTY_WIDTH. TDATA_BYTES=1 gives empty=0.
- Error:
  - tx_error[0] = rx_tuser[0], ORed with the keep violation flag.
  - Keep violation means any of: tkeep not contiguous from byte 0; a non-eop beat without all ones; a tkeep all-zero beat.
  - An all-zero keep beat is still forwarded, with empty = TDATA_BYTES-1 when it is eop.
  - tx_error[ERROR_WIDTH-1:1] = rx_tuser[ERROR_WIDTH-1:1] when TUSER_WIDTH permits, otherwise 0.
- Byte order:
  - FIRST_SYMBOL_IN_HIGH_ORDER_BITS=1: tx_data[TDATA_BYTES-1-i] = rx_tdata[i].
  - Otherwise the data passes straight through.
- Channel: tx_channel = rx_tid, captured per beat.
- Reset mid-packet: the in-flight beats are discarded and the FSM returns to IDLE. The next accepted beat gets sop=1.

Optional Feature:
Macro LOGIC_AXI4_STREAM_TO_AVALON_ST_TID_CHECK_EN.
- Defined:
  - The FSM stores the tid of the first beat of the packet.
  - Any IN_PACKET beat whose rx_tid differs sets tx_error[0] on that beat.
  - tx_channel still carries that beat's own rx_tid.
- Undefined: no tid register and no check; tid passes through per beat.

Decomposition:
- Package logic_axi4_stream_to_avalon_st_pkg holds:
  - the state_t enum {IDLE, IN_PACKET};
  - function keep_to_empty(keep), which returns empty and a contiguity flag;
  - function reorder_bytes.
- Sub-module logic_axi4_stream_to_avalon_st_skid: a generic 2-entry registered skid buffer with a packed-payload WIDTH parameter, instantiated once with {sop, eop, channel, error, empty, data}.

Test Plan:
- 3-beat packet, TDATA_BYTES=4, tkeep=F/F/3, tid=2, tx_ready=1 -> beats carry sop=1/0/0, eop=0/0/1, empty=0/0/2, channel=2, error=0; each output one cycle after its input.
- Back-to-back single-beat packets with tlast=1, tkeep=F, 8 beats -> sop=eop=1 every beat, 1 beat/cycle, rx_tready stays 1.
- Backpressure: tx_ready=0 for 5 cycles during streaming -> rx_tready=0 after 2 beats are buffered; no beat lost or duplicated; order preserved on release.
- Byte order: rx_tdata=0x44332211 with FIRST_SYMBOL_IN_HIGH_ORDER_BITS=1 -> tx_data=0x11223344. With 0 -> tx_data=0x44332211.
- Keep violations:
  - tkeep=0x5 with tlast -> error[0]=1, empty=2.
  - tkeep=0x7 without tlast -> error[0]=1.
  - tuser=1 on a clean beat -> error[0]=1.
- Reset mid-packet after beat 1 of 3, then a new packet -> no stale tx_valid; the first new beat has sop=1. With the TID_CHECK macro, a tid change 1->3 mid-packet -> error[0]=1 on that beat.
